// File: rtl/wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue_pkg
// Description : Shared types and widths for the writeback queue. A queue entry
//               is one pending register-file write: {destination, data}.
// Revision    : 1.0  initial release
// ============================================================================
package wb_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage : wb_queue_pkg
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwd_match
// Description : Priority match of one operand read address against the
//               occupied queue entries. Entries are scanned oldest to youngest
//               (head outward) so the youngest match is the one that sticks.
// Ports       : entries  - whole queue storage
//               head     - index of oldest entry
//               count    - number of occupied entries
//               rsrc     - operand register address to look up
//               hit      - some occupied entry targets rsrc
//               data     - data of the youngest such entry (0 if no hit)
// Revision    : 1.0  initial release
// ============================================================================
module wb_fwd_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]             entries,
    input  logic [$clog2(DEPTH)-1:0]          head,
    input  logic [$clog2(DEPTH+1)-1:0]        count,
    input  logic [REG_ADDR_W-1:0]             rsrc,
    output logic                              hit,
    output logic [XLEN-1:0]                   data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = '0;
        // Age k = 0 is the head (oldest); later ages overwrite earlier ones,
        // giving youngest-wins priority without an explicit encoder.
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (entries[w_idx].rd == rsrc)) begin
                hit  = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule : wb_fwd_match
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : In-order writeback queue in front of the register file write
//               port. Accepts an ALU result and an MDU result per cycle (ALU
//               is older), drains one entry per cycle onto Rdst/wdata/writereg.
//               Build option WB_QUEUE_FWD_EN: forward the youngest pending
//               write for Rsrc1/Rsrc2; otherwise the fwd outputs are tied 0.
// Ports       : clk, rst                    - clock, sync active-high reset
//               alu_valid/rd/data, alu_ready - ALU result handshake
//               mdu_valid/rd/data, mdu_ready - MDU result handshake
//               wb_hold                      - freeze draining
//               Rdst, wdata, writereg        - register file write port
//               count                        - occupied entries
//               Rsrc1/2, fwdN_hit, fwdN_data - operand forwarding
// Revision    : 1.0  initial release
// ============================================================================
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [REG_ADDR_W-1:0]         alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    output logic                          alu_ready,
    input  logic                          mdu_valid,
    input  logic [REG_ADDR_W-1:0]         mdu_rd,
    input  logic [XLEN-1:0]               mdu_data,
    output logic                          mdu_ready,
    input  logic                          wb_hold,
    output logic [REG_ADDR_W-1:0]         Rdst,
    output logic [XLEN-1:0]               wdata,
    output logic                          writereg,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    input  logic [REG_ADDR_W-1:0]         Rsrc1,
    input  logic [REG_ADDR_W-1:0]         Rsrc2,
    output logic                          fwd1_hit,
    output logic                          fwd2_hit,
    output logic [XLEN-1:0]               fwd1_data,
    output logic [XLEN-1:0]               fwd2_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_depth_m1 = CNT_W'(DEPTH-1);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_alu_push;
    logic                  w_mdu_push;
    logic                  w_pop;
    logic                  w_not_empty;
    logic [PTR_W-1:0]      w_mdu_slot;
    wb_entry_t             w_head_entry;

    // ------------------------------------------------------------------
    // Handshake. Readiness ignores a same-cycle pop, and mdu_ready only
    // looks at alu_valid so mdu_valid never reaches an output.
    // ------------------------------------------------------------------
    assign w_not_empty = (r_count != '0);
    assign alu_ready   = !rst && (r_count < c_depth);
    assign mdu_ready   = !rst && (alu_valid ? (r_count < c_depth_m1)
                                            : (r_count < c_depth));
    assign w_alu_push  = alu_valid && alu_ready;
    assign w_mdu_push  = mdu_valid && mdu_ready;

    assign writereg    = !rst && w_not_empty && !wb_hold;
    assign w_pop       = writereg;

    // The MDU entry lands one slot behind the ALU entry when both push.
    assign w_mdu_slot  = r_tail + PTR_W'(w_alu_push);

    assign w_head_entry = r_mem[r_head];
    assign Rdst         = w_not_empty ? w_head_entry.rd   : '0;
    assign wdata        = w_not_empty ? w_head_entry.data : '0;
    assign count        = r_count;

    // Storage is not reset: occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_mem[r_tail].rd   <= alu_rd;
            r_mem[r_tail].data <= alu_data;
        end
        if (w_mdu_push) begin
            r_mem[w_mdu_slot].rd   <= mdu_rd;
            r_mem[w_mdu_slot].data <= mdu_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_alu_push) + PTR_W'(w_mdu_push);
            r_count <= r_count + CNT_W'(w_alu_push) + CNT_W'(w_mdu_push)
                       - CNT_W'(w_pop);
        end
    end

`ifdef WB_QUEUE_FWD_EN
    wb_fwd_match #(
        .DEPTH   (DEPTH)
    ) u_fwd1 (
        .entries (r_mem),
        .head    (r_head),
        .count   (r_count),
        .rsrc    (Rsrc1),
        .hit     (fwd1_hit),
        .data    (fwd1_data)
    );

    wb_fwd_match #(
        .DEPTH   (DEPTH)
    ) u_fwd2 (
        .entries (r_mem),
        .head    (r_head),
        .count   (r_count),
        .rsrc    (Rsrc2),
        .hit     (fwd2_hit),
        .data    (fwd2_data)
    );
`else
    logic w_unused_rsrc;
    assign w_unused_rsrc = ^{Rsrc1, Rsrc2};

    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule : wb_queue
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_queue
// Description : Self-checking bench for wb_queue. A driver issues directed and
//               random traffic, keeps a list-of-pending-writes model and pushes
//               each accepted result onto a scoreboard; a monitor pops the
//               scoreboard whenever the DUT writes the register file.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mdu_valid, wb_hold;
    logic [4:0]  alu_rd, mdu_rd, Rsrc1, Rsrc2;
    logic [31:0] alu_data, mdu_data;
    logic        alu_ready, mdu_ready, writereg;
    logic [4:0]  Rdst;
    logic [31:0] wdata;
    logic [2:0]  count;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mdu_valid (mdu_valid),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .wb_hold   (wb_hold),
        .Rdst      (Rdst),
        .wdata     (wdata),
        .writereg  (writereg),
        .count     (count),
        .Rsrc1     (Rsrc1),
        .Rsrc2     (Rsrc2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t pend[$];       // model: writes accepted but not yet performed
    wr_t sb[$];         // scoreboard: expected register-file write order
    bit  last_mdu_acc;
    int  mdu_accepts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Newest pending data for a register, scanning from youngest.
    task automatic model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].rd == r) begin
                hit = 1'b1;
                d   = pend[i].data;
                break;
            end
        end
    endtask

    // Monitor: every register-file write must be the next scoreboard entry.
    always @(negedge clk) begin
        if (writereg === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected actual=r%0d:%0h expected=none", Rdst, wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_rd", 32'(Rdst), 32'(e.rd));
                chk("wr_data", wdata, e.data);
            end
        end
    end

    // One clock cycle: inputs already driven just after the previous edge.
    // Checks at the falling edge, model update at the rising edge.
    task automatic cycle(input bit r, input bit av, input logic [4:0] ard,
                         input logic [31:0] ad, input bit hold);
        int  n;
        bit  e_ar, e_mr, e_wr, a_acc, m_acc, h;
        logic [31:0] d;
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad; wb_hold = hold;
        @(negedge clk);
        n    = pend.size();
        e_ar = !r && (n < DEPTH);
        e_mr = !r && (n + int'(av) < DEPTH);
        e_wr = !r && (n != 0) && !hold;
        chk("count", 32'(count), 32'(n));
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("mdu_ready", 32'(mdu_ready), 32'(e_mr));
        chk("writereg", 32'(writereg), 32'(e_wr));
        chk("Rdst", 32'(Rdst), (n != 0) ? 32'(pend[0].rd) : 32'd0);
        chk("wdata", wdata, (n != 0) ? pend[0].data : 32'd0);
`ifdef WB_QUEUE_FWD_EN
        model_fwd(Rsrc1, h, d);
        chk("fwd1_hit", 32'(fwd1_hit), 32'(h));
        chk("fwd1_data", fwd1_data, d);
        model_fwd(Rsrc2, h, d);
        chk("fwd2_hit", 32'(fwd2_hit), 32'(h));
        chk("fwd2_data", fwd2_data, d);
`else
        h = 1'b0;
        d = '0;
        chk("fwd1_hit", 32'(fwd1_hit), 32'(h));
        chk("fwd2_data", fwd2_data, d);
`endif
        a_acc = av && e_ar;
        m_acc = mdu_valid && e_mr;
        @(posedge clk);
        if (r) begin
            pend.delete();
            sb.delete();
        end else begin
            if (e_wr) void'(pend.pop_front());
            if (a_acc) begin pend.push_back('{ard, ad}); sb.push_back('{ard, ad}); end
            if (m_acc) begin
                pend.push_back('{mdu_rd, mdu_data});
                sb.push_back('{mdu_rd, mdu_data});
                mdu_accepts++;
            end
        end
        last_mdu_acc = m_acc;
        #1;
        if (m_acc) mdu_valid = 1'b0;
    endtask

    task automatic set_mdu(input bit v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = v; mdu_rd = rd; mdu_data = d;
    endtask

    initial begin
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0; wb_hold = 0;
        Rsrc1 = 5'd7; Rsrc2 = 5'd8;
        mdu_accepts = 0;

        // Reset, then idle.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Single ALU push, minimum latency.
        cycle(0, 1, 5'd5, 32'hDEADBEEF, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Same-cycle ALU then MDU.
        set_mdu(1, 5'd2, 32'h22);
        cycle(0, 1, 5'd1, 32'h11, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Fill under hold; count=3 with alu_valid blocks MDU; MDU held while full.
        cycle(0, 1, 5'd10, 32'hA0, 1);
        cycle(0, 1, 5'd11, 32'hA1, 1);
        cycle(0, 1, 5'd12, 32'hA2, 1);
        set_mdu(1, 5'd13, 32'hB3);
        cycle(0, 1, 5'd14, 32'hA4, 1);       // count 3: ALU in, MDU refused
        mdu_accepts = 0;
        cycle(0, 1, 5'd15, 32'hA5, 1);       // full: both refused
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);                // pop, still not ready
        repeat (6) cycle(0, 0, 0, 0, 0);
        chk("mdu_once", 32'(mdu_accepts), 32'd1);

        // Forwarding: two writes to r7, youngest wins.
        cycle(0, 1, 5'd7, 32'h1, 1);
        cycle(0, 1, 5'd7, 32'h2, 1);
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Reset mid-fill.
        cycle(0, 1, 5'd3, 32'h33, 1);
        set_mdu(1, 5'd4, 32'h44);
        cycle(0, 1, 5'd3, 32'h34, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        set_mdu(0, 0, 0);

        // Random traffic; the MDU holds its result until accepted.
        for (int i = 0; i < 2000; i++) begin
            Rsrc1 = 5'($urandom_range(0, 7));
            Rsrc2 = 5'($urandom_range(0, 7));
            if (!mdu_valid && ($urandom_range(0, 2) == 0))
                set_mdu(1, 5'($urandom_range(0, 7)), $urandom);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0));
        end

        // Drain with a bounded number of cycles.
        set_mdu(0, 0, 0);
        for (int i = 0; i < 20 && pend.size() != 0; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wb_queue
`default_nettype wire
